// File: rtl/box_draw_scheduler_pkg.sv
// box_draw_scheduler_pkg: shared types for the box draw scheduler.
//   drawStateT : scheduler FSM states (IDLE, LAUNCH, WAIT_DONE, GAP)
//   boxReqT    : box request {xLeft, xRight, yTop, yBottom} at default widths
//   XSZ_DEF/YSZ_DEF : default coordinate widths
package box_draw_scheduler_pkg;
    localparam int XSZ_DEF = 8;
    localparam int YSZ_DEF = 7;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} drawStateT;
    typedef struct packed {
        logic [XSZ_DEF-1:0] xLeft;
        logic [XSZ_DEF-1:0] xRight;
        logic [YSZ_DEF-1:0] yTop;
        logic [YSZ_DEF-1:0] yBottom;
    } boxReqT;
endpackage

// File: rtl/box_req_fifo.sv
// box_req_fifo: synchronous FIFO of box requests with flush.
//   clk, resetn (sync, active-low)
//   push/pushData : write an entry (caller guarantees !full)
//   pop           : drop the head (caller guarantees !empty)
//   flush         : empty the FIFO next cycle; overrides push and pop
//   head          : current head entry, read from registered storage
//   full, empty   : occupancy flags
module box_req_fifo
    import box_draw_scheduler_pkg::*;
#(
    parameter type T     = boxReqT,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  T     pushData,
    input  logic pop,
    input  logic flush,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count;

    assign head  = mem[rdPtr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk)
        if (push && !flush) mem[wrPtr] <= pushData;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/box_draw_scheduler.sv
// box_draw_scheduler: queues box requests and sequences the box-outline drawer one box at a time.
//   clk, resetn (sync, active-low)
//   req_valid/req_ready, req_x_left/right, req_y_top/bottom : request push interface
//   flush      : discard queued (not in-flight) requests
//   go_draw    : one-cycle start pulse to the drawer
//   x_left/x_right/y_top/y_bottom : coordinates held from launch until the next launch
//   done_draw  : drawer completion pulse
//   busy       : box in flight (LAUNCH, WAIT_DONE, GAP)
//   timeout_err: sticky watchdog abort flag
//   boxes_drawn: saturating completed-box count
// Optional macro BOX_NORMALIZE_EN: order each box's x and y pairs when it is popped.
module box_draw_scheduler
    import box_draw_scheduler_pkg::*;
#(
    parameter int XSZ     = XSZ_DEF,
    parameter int YSZ     = YSZ_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 20000,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XSZ-1:0]   req_x_left,
    input  logic [XSZ-1:0]   req_x_right,
    input  logic [YSZ-1:0]   req_y_top,
    input  logic [YSZ-1:0]   req_y_bottom,
    input  logic             flush,
    output logic             go_draw,
    output logic [XSZ-1:0]   x_left,
    output logic [XSZ-1:0]   x_right,
    output logic [YSZ-1:0]   y_top,
    output logic [YSZ-1:0]   y_bottom,
    input  logic             done_draw,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] boxes_drawn
);
    localparam int WD_W = $clog2(TIMEOUT);

    typedef struct packed {
        logic [XSZ-1:0] xLeft;
        logic [XSZ-1:0] xRight;
        logic [YSZ-1:0] yTop;
        logic [YSZ-1:0] yBottom;
    } boxT;

    drawStateT state;
    logic [WD_W-1:0] wdog;
    boxT reqBox, head, popBox;
    logic full, empty, pop;

    assign reqBox    = '{req_x_left, req_x_right, req_y_top, req_y_bottom};
    assign req_ready = !full;
    assign pop       = state == IDLE && !empty;

    box_req_fifo #(.T(boxT), .DEPTH(DEPTH)) uFifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (req_valid && !full),
        .pushData(reqBox),
        .pop     (pop),
        .flush   (flush),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

`ifdef BOX_NORMALIZE_EN
    assign popBox.xLeft   = head.xLeft > head.xRight ? head.xRight : head.xLeft;
    assign popBox.xRight  = head.xLeft > head.xRight ? head.xLeft : head.xRight;
    assign popBox.yTop    = head.yTop > head.yBottom ? head.yBottom : head.yTop;
    assign popBox.yBottom = head.yTop > head.yBottom ? head.yTop : head.yBottom;
`else
    assign popBox = head;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            wdog        <= '0;
            go_draw     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            boxes_drawn <= '0;
            x_left      <= '0;
            x_right     <= '0;
            y_top       <= '0;
            y_bottom    <= '0;
        end else begin
            go_draw <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    state    <= LAUNCH;
                    go_draw  <= 1'b1;
                    busy     <= 1'b1;
                    x_left   <= popBox.xLeft;
                    x_right  <= popBox.xRight;
                    y_top    <= popBox.yTop;
                    y_bottom <= popBox.yBottom;
                end
                LAUNCH: begin
                    state <= WAIT_DONE;
                    wdog  <= '0;
                end
                WAIT_DONE: if (done_draw) begin
                    state       <= GAP;
                    boxes_drawn <= boxes_drawn + {{(CNT_W-1){1'b0}}, ~&boxes_drawn};
                end else if (wdog == WD_W'(TIMEOUT-1)) begin
                    state       <= GAP;
                    timeout_err <= 1'b1;
                end else begin
                    wdog <= wdog + 1'b1;
                end
                // go_draw is low here, letting the drawer leave its done state
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_box_draw_scheduler.sv
// tb_box_draw_scheduler: directed and randomized check of box_draw_scheduler against a queue-based model.
module tb_box_draw_scheduler;
    localparam int XSZ = 8, YSZ = 7, DEPTH = 4, TIMEOUT = 40, CNT_W = 4;

    logic clk = 0, resetn = 0, req_valid = 0, flush = 0, done_draw = 0;
    logic [XSZ-1:0] req_x_left = 0, req_x_right = 0;
    logic [YSZ-1:0] req_y_top = 0, req_y_bottom = 0;
    logic req_ready, go_draw, busy, timeout_err;
    logic [XSZ-1:0] x_left, x_right;
    logic [YSZ-1:0] y_top, y_bottom;
    logic [CNT_W-1:0] boxes_drawn;

    int checks = 0, errors = 0;
    bit on = 0;

    always #5 clk = ~clk;

    box_draw_scheduler #(.XSZ(XSZ), .YSZ(YSZ), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_x_left(req_x_left), .req_x_right(req_x_right), .req_y_top(req_y_top), .req_y_bottom(req_y_bottom),
        .flush(flush), .go_draw(go_draw), .x_left(x_left), .x_right(x_right), .y_top(y_top), .y_bottom(y_bottom),
        .done_draw(done_draw), .busy(busy), .timeout_err(timeout_err), .boxes_drawn(boxes_drawn)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending boxes in a queue, the in-flight box, and how long it has been out.
    // phase: 0 nothing in flight, 1 start pulse cycle, 2 waiting for the drawer, 3 settle cycle.
    typedef struct {int xl, xr, yt, yb;} boxM;
    boxM q[$];
    boxM cur;
    int phase = 0, waited = 0, mCnt = 0;
    bit mErr = 0;

    function automatic boxM norm(boxM b);
        boxM r = b;
`ifdef BOX_NORMALIZE_EN
        if (b.xl > b.xr) begin r.xl = b.xr; r.xr = b.xl; end
        if (b.yt > b.yb) begin r.yt = b.yb; r.yb = b.yt; end
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        bit pushOk;
        if (!resetn) begin
            q.delete();
            cur = '{0, 0, 0, 0};
            phase = 0;
            mCnt = 0;
            mErr = 0;
        end else begin
            pushOk = req_valid && q.size() < DEPTH;
            if (phase == 0) begin
                if (q.size() > 0) begin
                    cur = norm(q.pop_front());
                    phase = 1;
                end
            end else if (phase == 1) begin
                phase = 2;
                waited = 0;
            end else if (phase == 2) begin
                waited++;
                if (done_draw) begin
                    phase = 3;
                    if (mCnt < (1 << CNT_W) - 1) mCnt++;
                end else if (waited == TIMEOUT) begin
                    phase = 3;
                    mErr = 1;
                end
            end else phase = 0;
            if (flush) q.delete();
            else if (pushOk) q.push_back('{int'(req_x_left), int'(req_x_right), int'(req_y_top), int'(req_y_bottom)});
        end
    end

    always @(negedge clk) if (on) begin
        chk("req_ready", req_ready, q.size() < DEPTH);
        chk("go_draw", go_draw, phase == 1);
        chk("busy", busy, phase != 0);
        chk("timeout_err", timeout_err, mErr);
        chk("boxes_drawn", boxes_drawn, mCnt);
        chk("x_left", x_left, cur.xl);
        chk("x_right", x_right, cur.xr);
        chk("y_top", y_top, cur.yt);
        chk("y_bottom", y_bottom, cur.yb);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushBox(input int xl, input int xr, input int yt, input int yb);
        req_valid = 1;
        req_x_left = XSZ'(xl);
        req_x_right = XSZ'(xr);
        req_y_top = YSZ'(yt);
        req_y_bottom = YSZ'(yb);
        step();
        req_valid = 0;
    endtask

    task automatic pulseDone();
        done_draw = 1;
        step();
        done_draw = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        on = 1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_go", go_draw, 0);
        chk("rst_cnt", boxes_drawn, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_xl", x_left, 0);
        step();
        resetn = 1;

        // single box: go two cycles after the push, coordinates held until done
        pushBox(10, 20, 5, 15);
        @(negedge clk);
        chk("single_go_early", go_draw, 0);
        step();
        @(negedge clk);
        chk("single_go", go_draw, 1);
        chk("single_xl", x_left, 10);
        chk("single_xr", x_right, 20);
        chk("single_yt", y_top, 5);
        chk("single_yb", y_bottom, 15);
        repeat (3) step();
        @(negedge clk);
        chk("hold_xl", x_left, 10);
        chk("hold_yb", y_bottom, 15);
        chk("hold_busy", busy, 1);
        pulseDone();
        @(negedge clk);
        chk("single_cnt", boxes_drawn, 1);
        chk("gap_busy", busy, 1);
        step();
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // reversed box
        pushBox(50, 10, 40, 2);
        step();
        @(negedge clk);
`ifdef BOX_NORMALIZE_EN
        chk("norm_xl", x_left, 10);
        chk("norm_xr", x_right, 50);
        chk("norm_yt", y_top, 2);
        chk("norm_yb", y_bottom, 40);
`else
        chk("pass_xl", x_left, 50);
        chk("pass_xr", x_right, 10);
        chk("pass_yt", y_top, 40);
        chk("pass_yb", y_bottom, 2);
`endif
        repeat (2) step();
        pulseDone();
        repeat (2) step();

        // back-to-back pushes while drawing: fifo fills at DEPTH
        pushBox(1, 2, 3, 4);
        step();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1;
            req_x_left = XSZ'(20 + i);
            req_x_right = XSZ'(40 + i);
            req_y_top = YSZ'(i);
            req_y_bottom = YSZ'(60 + i);
            step();
            if (i == 2) begin @(negedge clk); chk("ready_at3", req_ready, 1); end
            if (i == 3) begin @(negedge clk); chk("ready_at4", req_ready, 0); end
        end
        req_valid = 0;
        repeat (5) begin
            repeat (4) step();
            pulseDone();
        end
        repeat (3) step();
        @(negedge clk);
        chk("drain_ready", req_ready, 1);
        chk("drain_busy", busy, 0);

        // watchdog: no done for TIMEOUT cycles, next queued box follows the gap
        pushBox(7, 8, 9, 10);
        pushBox(3, 4, 5, 6);
        repeat (TIMEOUT) step();
        @(negedge clk);
        chk("wd_before", timeout_err, 0);
        step();
        @(negedge clk);
        chk("wd_err", timeout_err, 1);
        chk("wd_gap_busy", busy, 1);
        chk("wd_cnt", boxes_drawn, mCnt);
        step();
        @(negedge clk);
        chk("wd_idle_go", go_draw, 0);
        step();
        @(negedge clk);
        chk("wd_next_go", go_draw, 1);
        chk("wd_next_xl", x_left, 3);
        repeat (2) step();
        pulseDone();
        repeat (2) step();

        // flush during WAIT_DONE drops queued boxes but not the in-flight one
        pushBox(1, 1, 1, 1);
        repeat (2) step();
        pushBox(11, 12, 13, 14);
        pushBox(21, 22, 23, 24);
        pushBox(31, 32, 33, 34);
        flush = 1;
        step();
        flush = 0;
        @(negedge clk);
        chk("flush_ready", req_ready, 1);
        chk("flush_busy", busy, 1);
        pulseDone();
        repeat (8) step();
        @(negedge clk);
        chk("flush_idle", busy, 0);
        chk("flush_xl", x_left, 1);

        // reset while waiting for the drawer
        pushBox(2, 3, 4, 5);
        repeat (3) step();
        pushBox(6, 7, 8, 9);
        resetn = 0;
        step();
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", boxes_drawn, 0);
        chk("mid_rst_go", go_draw, 0);
        chk("mid_rst_ready", req_ready, 1);
        resetn = 1;
        step();
        @(negedge clk);
        chk("mid_rst_empty", busy, 0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            req_valid = $urandom_range(0, 2) != 0;
            req_x_left = XSZ'($urandom);
            req_x_right = XSZ'($urandom);
            req_y_top = YSZ'($urandom);
            req_y_bottom = YSZ'($urandom);
            flush = $urandom_range(0, 40) == 0;
            done_draw = ((c / 400) % 3 == 2) ? $urandom_range(0, 199) == 0 : $urandom_range(0, 5) == 0;
            resetn = $urandom_range(0, 1499) != 0;
            step();
        end
        req_valid = 0;
        flush = 0;
        done_draw = 0;
        resetn = 1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
